// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM encoding, width derivation and convolution index bounds
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Worst case sum is depth * max_x * max_y, so log2(depth) extra bits suffice.
    function automatic int acc_width(input int xw, input int yw, input int depth);
        return xw + yw + clog2(depth);
    endfunction

    function automatic int bound_kmin(input int n, input int size_y);
        return (n >= size_y) ? n - size_y + 1 : 0;
    endfunction

    function automatic int bound_kmax(input int n, input int size_x);
        return (n < size_x) ? n : size_x - 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - delayed-valid multiply-accumulate with truncating or saturating output (CONV_SAT_EN)
module conv_mac #(
    parameter int XW        = 8,
    parameter int YW        = 8,
    parameter int ZW        = 16,
    parameter int ACC_WIDTH = 21
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          issue,
    input  logic [XW-1:0] data_x,
    input  logic [YW-1:0] data_y,
    output logic [ZW-1:0] result
`ifdef CONV_SAT_EN
    ,
    output logic          sat
`endif
);

    logic                 vld;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [XW+YW-1:0]     prod;

    // result looks through the pending product so the top can register it
    // on the same edge that absorbs the last term.
    always_comb begin
        prod    = {{YW{1'b0}}, data_x} * {{XW{1'b0}}, data_y};
        acc_nxt = vld ? acc + ACC_WIDTH'(prod) : acc;
`ifdef CONV_SAT_EN
        sat     = (acc_nxt >> ZW) != '0;
        result  = sat ? '1 : ZW'(acc_nxt);
`else
        result  = ZW'(acc_nxt);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= 1'b0;
            acc <= '0;
        end else begin
            vld <= issue;
            acc <= clr ? '0 : acc_nxt;
        end
    end

endmodule

// File: rtl/conv_processor_mc.sv
// rtl/conv_processor_mc.sv - runtime-sized linear convolution engine; CONV_SAT_EN adds saturation and sat_o
module conv_processor_mc
    import conv_pkg::*;
#(
    parameter int DATA_X_WIDTH    = 8,
    parameter int DATA_Y_WIDTH    = 8,
    parameter int DATA_Z_WIDTH    = 16,
    parameter int MEMX_ADDR_WIDTH = 5,
    parameter int MEMY_ADDR_WIDTH = 5,
    parameter int MEMZ_ADDR_WIDTH = 6,
    parameter int SIZE_WIDTH      = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [SIZE_WIDTH-1:0]      sizeX_i,
    input  logic [SIZE_WIDTH-1:0]      sizeY_i,
    input  logic [DATA_X_WIDTH-1:0]    dataX_i,
    output logic [MEMX_ADDR_WIDTH-1:0] memX_addr_o,
    input  logic [DATA_Y_WIDTH-1:0]    dataY_i,
    output logic [MEMY_ADDR_WIDTH-1:0] memY_addr_o,
    output logic [DATA_Z_WIDTH-1:0]    dataZ_o,
    output logic [MEMZ_ADDR_WIDTH-1:0] memZ_addr_o,
    output logic                       writeZ_o,
    output logic                       busy_o,
    output logic                       done_o
`ifdef CONV_SAT_EN
    ,
    output logic                       sat_o
`endif
);

    localparam int DEPTH_X   = 2 ** MEMX_ADDR_WIDTH;
    localparam int DEPTH_Y   = 2 ** MEMY_ADDR_WIDTH;
    localparam int ACC_WIDTH = acc_width(DATA_X_WIDTH, DATA_Y_WIDTH, DEPTH_X);

    state_t                     state;
    logic [SIZE_WIDTH-1:0]      size_x;
    logic [SIZE_WIDTH-1:0]      size_y;
    logic [SIZE_WIDTH-1:0]      sx_clamped;
    logic [SIZE_WIDTH-1:0]      sy_clamped;
    logic [MEMZ_ADDR_WIDTH-1:0] n;
    logic [MEMZ_ADDR_WIDTH-1:0] n_nx;
    int                         kmin_nx;
    int                         kmax_cur;
    int                         n_last;
    logic                       mac_clr;
    logic                       mac_issue;
    logic [DATA_Z_WIDTH-1:0]    z_result;
`ifdef CONV_SAT_EN
    logic                       z_sat;
`endif

    always_comb begin
        sx_clamped = (sizeX_i > SIZE_WIDTH'(DEPTH_X)) ? SIZE_WIDTH'(DEPTH_X) : sizeX_i;
        sy_clamped = (sizeY_i > SIZE_WIDTH'(DEPTH_Y)) ? SIZE_WIDTH'(DEPTH_Y) : sizeY_i;
        n_nx       = n + MEMZ_ADDR_WIDTH'(1);
        kmin_nx    = bound_kmin(int'(n_nx), int'(size_y));
        kmax_cur   = bound_kmax(int'(n), int'(size_x));
        n_last     = int'(size_x) + int'(size_y) - 2;
        mac_clr    = (state == S_CHECK) || (state == S_WRITE);
        mac_issue  = (state == S_FETCH);
    end

    conv_mac #(
        .XW       (DATA_X_WIDTH),
        .YW       (DATA_Y_WIDTH),
        .ZW       (DATA_Z_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (mac_clr),
        .issue (mac_issue),
        .data_x(dataX_i),
        .data_y(dataY_i),
        .result(z_result)
`ifdef CONV_SAT_EN
        ,
        .sat   (z_sat)
`endif
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            size_x      <= '0;
            size_y      <= '0;
            n           <= '0;
            memX_addr_o <= '0;
            memY_addr_o <= '0;
            dataZ_o     <= '0;
            memZ_addr_o <= '0;
            writeZ_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
`ifdef CONV_SAT_EN
            sat_o       <= 1'b0;
`endif
        end else begin
            writeZ_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        size_x <= sx_clamped;
                        size_y <= sy_clamped;
                        busy_o <= 1'b1;
                        state  <= S_CHECK;
`ifdef CONV_SAT_EN
                        sat_o  <= 1'b0;
`endif
                    end
                end
                S_CHECK: begin
                    if (size_x == '0 || size_y == '0) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        n           <= '0;
                        memX_addr_o <= '0;
                        memY_addr_o <= '0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (int'(memX_addr_o) == kmax_cur) begin
                        state <= S_DRAIN;
                    end else begin
                        memX_addr_o <= memX_addr_o + MEMX_ADDR_WIDTH'(1);
                        memY_addr_o <= memY_addr_o - MEMY_ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    writeZ_o    <= 1'b1;
                    memZ_addr_o <= n;
                    dataZ_o     <= z_result;
`ifdef CONV_SAT_EN
                    if (z_sat) sat_o <= 1'b1;
`endif
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    if (int'(n) == n_last) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        n           <= n_nx;
                        memX_addr_o <= MEMX_ADDR_WIDTH'(kmin_nx);
                        memY_addr_o <= MEMY_ADDR_WIDTH'(int'(n_nx) - kmin_nx);
                        state       <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
